pc_fetch_unit: RTL
==================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port npc_in  input  32  next-PC value from the upstream 32-bit 2:1 next-PC mux (pc_plus4 vs branch target).
REQ-005 SHALL have port npc_valid  input  1  npc_in is resolved for the current instruction.
REQ-006 SHALL have port stall  input  1  blocks the PC update while high.
REQ-007 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-008 SHALL have port imem_addr  output  32  read address, equal to pc_out.
REQ-009 SHALL have port imem_ack  input  1  memory read complete; imem_rdata valid this cycle.
REQ-010 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-011 SHALL have port instr_out  output  32  registered instruction for decode.
REQ-012 SHALL have port instr_valid  output  1  instr_out is offered to decode.
REQ-013 SHALL have port instr_ready  input  1  decode accepts instr_out.
REQ-014 SHALL have port pc_out  output  32  current PC.
REQ-015 SHALL have port pc_plus4  output  32  pc_out+4; drives input a of the next-PC mux.
REQ-016 SHALL have port instr_count  output  32  count of issued instructions.
REQ-017 SHALL have port misalign_err  output  1  sticky misaligned-target flag.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, ISSUE, NEXT, HALT; imem_req=1 only in FETCH; instr_valid=1 only in ISSUE.
REQ-019 SHALL go IDLE->FETCH unconditionally on the first clock edge after rst_n deasserts.
REQ-020 SHALL, in FETCH, hold imem_req=1 and imem_addr=pc_out until imem_ack=1; on imem_ack, capture imem_rdata into instr_out and go to ISSUE. An ack in the first FETCH cycle is legal.
REQ-021 SHALL ignore imem_ack outside FETCH.
REQ-022 SHALL, in ISSUE, hold instr_out stable; on instr_ready=1, increment instr_count and go to NEXT.
REQ-023 SHALL, in NEXT, on npc_valid=1 and stall=0, load pc_out<=npc_in and go to FETCH; otherwise hold.
REQ-024 SHALL ignore npc_valid outside NEXT; when npc_valid and stall are both high, stall wins.
REQ-025 SHALL compute pc_plus4 combinationally, modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-026 SHALL wrap instr_count from 32'hFFFF_FFFF to 0 without a flag.
REQ-027 SHALL make a new address visible on imem_addr one cycle after the NEXT->FETCH edge.
REQ-028 SHALL stay in HALT until reset, with imem_req=0 and instr_valid=0.

Reset
REQ-029 SHALL, while rst_n=0, force state=IDLE, pc_out=RESET_PC, instr_out=0, instr_count=0 and misalign_err=0, and drive imem_req=0 and instr_valid=0, immediately and without waiting for clk.
REQ-030 SHALL, on reset mid-fetch, drop the outstanding request and discard any later imem_ack for it.

Configuration
REQ-031 SHALL, with macro PC_ALIGN_CHECK_EN defined: in NEXT, when npc_valid=1, stall=0 and npc_in[1:0]!=0, leave pc_out unchanged, set misalign_err=1 (sticky) and go to HALT.
REQ-032 SHALL, without PC_ALIGN_CHECK_EN: load {npc_in[31:2],2'b00}, tie misalign_err to 0, and never enter HALT.

Verification
REQ-033 SHALL cover reset fetch: release rst_n, ack 2 cycles later with rdata=32'h1234_5678 -> imem_addr=RESET_PC, instr_out=32'h1234_5678, instr_valid=1.
REQ-034 SHALL cover sequential flow: instr_ready=1, npc_in=pc_plus4=32'h4, npc_valid=1 -> pc_out=32'h4, next request at 32'h4, instr_count=1.
REQ-035 SHALL cover stall priority: in NEXT, npc_valid=1 and stall=1 for 3 cycles, then stall=0 -> pc_out updates only on the cycle stall is low.
REQ-036 SHALL cover wrap: pc_out=32'hFFFF_FFFC -> pc_plus4=0; load npc_in=0 -> fetch at 32'h0.
REQ-037 SHALL cover async reset mid-FETCH: rst_n=0 between clock edges -> imem_req=0 immediately; a subsequent stray imem_ack is ignored; restart at RESET_PC.
REQ-038 SHALL cover misalignment with npc_in=32'h0000_0006: with PC_ALIGN_CHECK_EN -> misalign_err=1, HALT, no further imem_req; without -> fetch at 32'h0000_0004.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program-counter and instruction-fetch sequencer: IDLE -> FETCH -> ISSUE -> NEXT -> FETCH.
// Latency: request in the cycle after reset release or after a PC load; instr_out registered on imem_ack.
// Backpressure: holds ISSUE until instr_ready, holds NEXT while stall or !npc_valid; PC_ALIGN_CHECK_EN halts on misaligned targets.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] npc_in,
    input  logic        npc_valid,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr_count,
    output logic        misalign_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        NEXT  = 3'd3,
        HALT  = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_q, pc_nxt;
    logic [31:0] instr_q, instr_nxt;
    logic [31:0] cnt_q, cnt_nxt;
    logic        err_q, err_nxt;
    logic        npc_take;

    // Stall has priority over a resolved next PC.
    assign npc_take = npc_valid && !stall;

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc_q;
        instr_nxt   = instr_q;
        cnt_nxt     = cnt_q;
        err_nxt     = err_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_nxt = imem_rdata;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    cnt_nxt   = cnt_q + 32'd1;
                    state_nxt = NEXT;
                end
            end
            NEXT: begin
                if (npc_take) begin
`ifdef PC_ALIGN_CHECK_EN
                    if (npc_in[1:0] != 2'b00) begin
                        err_nxt   = 1'b1;
                        state_nxt = HALT;
                    end else begin
                        pc_nxt    = npc_in;
                        state_nxt = FETCH;
                    end
`else
                    pc_nxt    = {npc_in[31:2], 2'b00};
                    state_nxt = FETCH;
`endif
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            cnt_q   <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc_q    <= pc_nxt;
            instr_q <= instr_nxt;
            cnt_q   <= cnt_nxt;
            err_q   <= err_nxt;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    assign misalign_err = err_q;
`else
    // Without the check the target low bits are dropped, so the flag can never rise.
    logic unused_npc_lsb;
    assign unused_npc_lsb = ^{npc_in[1:0], err_q};
    assign misalign_err   = 1'b0;
`endif

    assign pc_out      = pc_q;
    assign imem_addr   = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign instr_out   = instr_q;
    assign instr_count = cnt_q;

endmodule
